// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: op encodings, access sizes,
// FSM states and the registered memory-drive bundle.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_SPLIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data_in;
    logic        read;
    logic        write;
    logic        half_word_mode;
    logic        byte_mode;
    logic        unsigned_mode;
  } mem_drv_t;

  function automatic logic is_store(op_e op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

  function automatic logic [2:0] op_size(op_e op);
    case (op)
      OP_LW, OP_SW:          return SIZE_WORD;
      OP_LH, OP_LHU, OP_SH:  return SIZE_HALF;
      default:               return SIZE_BYTE;
    endcase
  endfunction

  function automatic logic op_signed(op_e op);
    return op inside {OP_LH, OP_LB};
  endfunction

  // Memory is always read zero-extended; sign extension happens here.
  function automatic logic [31:0] extend_load(op_e op, logic [31:0] d);
    case (op_size(op))
      SIZE_HALF: return {{16{op_signed(op) & d[15]}}, d[15:0]};
      SIZE_BYTE: return {{24{op_signed(op) & d[7]}}, d[7:0]};
      default:   return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Datapath-side request/response handshake of the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/lsu_align_check.sv
// Combinational alignment / range classification of an incoming request.
module lsu_align_check
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  op_e         op,
  input  logic [31:0] addr,
  output logic        misaligned,
  output logic        out_of_range,
  output logic [2:0]  beats
);

  logic [2:0]  size;
  logic [32:0] last_byte;

  always_comb begin
    size = op_size(op);
    case (size)
      SIZE_WORD: misaligned = (addr[1:0] != 2'b00);
      SIZE_HALF: misaligned = addr[0];
      default:   misaligned = 1'b0;
    endcase
    // 33-bit sum so an access wrapping past 0xFFFFFFFF is out of range
    last_byte    = {1'b0, addr} + {30'b0, size} - 33'd1;
    out_of_range = (last_byte >= 33'(MEM_BYTES));
    beats        = misaligned ? size : 3'd1;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one-beat aligned accesses, misaligned halfword/word accesses
// split into big-endian byte beats, out-of-range/rejected requests answered with an error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES        = 1024,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  lsu_if.slave        dp,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_half_word_mode,
  output logic        mem_byte_mode,
  output logic        mem_unsigned_mode,
  input  logic [31:0] mem_data_out
);

  state_e      state;
  op_e         op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] asm_q;
  logic [2:0]  nbeats_q;
  logic [1:0]  beat_q;
  mem_drv_t    mem_q;

  op_e         req_op;
  logic        misaligned;
  logic        out_of_range;
  logic [2:0]  beats;
  logic        reject;
  logic        last_beat;
  logic [1:0]  asm_pos;
  logic [31:0] asm_next;

  assign req_op = op_e'(dp.req_op);

  lsu_align_check #(.MEM_BYTES(MEM_BYTES)) u_align (
    .op          (req_op),
    .addr        (dp.req_addr),
    .misaligned  (misaligned),
    .out_of_range(out_of_range),
    .beats       (beats)
  );

  always_comb begin
    reject    = out_of_range || (misaligned && !SPLIT_MISALIGNED);
    last_beat = ({1'b0, beat_q} == (nbeats_q - 3'd1));
    // beat i lands in byte lane N-1-i: first beat is the most significant byte
    asm_pos   = 2'(nbeats_q - 3'd1 - {1'b0, beat_q});
    asm_next  = asm_q;
    asm_next[{asm_pos, 3'b000} +: 8] = mem_data_out[7:0];
  end

  function automatic mem_drv_t mem_drive(op_e op, logic [31:0] addr, logic [31:0] wdata,
                                         logic split, logic [2:0] n, logic [1:0] beat);
    mem_drv_t   d;
    logic [1:0] pos;
    logic [2:0] size;
    d               = '0;
    size            = op_size(op);
    pos             = 2'(n - 3'd1 - {1'b0, beat});
    d.write         = is_store(op);
    d.read          = !d.write;
    d.unsigned_mode = d.read;
    if (split) begin
      d.address   = addr + {30'b0, beat};
      d.byte_mode = 1'b1;
      if (d.write) d.data_in = {24'b0, wdata[{pos, 3'b000} +: 8]};
    end else begin
      d.address        = addr;
      d.half_word_mode = (size == SIZE_HALF);
      d.byte_mode      = (size == SIZE_BYTE);
      if (d.write) d.data_in = wdata;
    end
    return d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      dp.req_ready  <= 1'b1;
      dp.resp_valid <= 1'b0;
      dp.resp_rdata <= '0;
      dp.resp_error <= 1'b0;
      mem_q         <= '0;
      op_q          <= OP_LW;
      addr_q        <= '0;
      wdata_q       <= '0;
      nbeats_q      <= 3'd1;
      beat_q        <= '0;
      asm_q         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dp.req_valid) begin
            op_q         <= req_op;
            addr_q       <= dp.req_addr;
            wdata_q      <= dp.req_wdata;
            nbeats_q     <= beats;
            beat_q       <= '0;
            asm_q        <= '0;
            dp.req_ready <= 1'b0;
            if (reject) begin
              state         <= ST_RESP;
              dp.resp_valid <= 1'b1;
              dp.resp_error <= 1'b1;
              dp.resp_rdata <= '0;
            end else if (misaligned) begin
              state <= ST_SPLIT;
              mem_q <= mem_drive(req_op, dp.req_addr, dp.req_wdata, 1'b1, beats, 2'd0);
            end else begin
              state <= ST_ACCESS;
              mem_q <= mem_drive(req_op, dp.req_addr, dp.req_wdata, 1'b0, beats, 2'd0);
            end
          end
        end
        ST_ACCESS: begin
          mem_q         <= '0;
          state         <= ST_RESP;
          dp.resp_valid <= 1'b1;
          dp.resp_error <= 1'b0;
          dp.resp_rdata <= is_store(op_q) ? '0 : extend_load(op_q, mem_data_out);
        end
        ST_SPLIT: begin
          asm_q <= asm_next;
          if (last_beat) begin
            mem_q         <= '0;
            state         <= ST_RESP;
            dp.resp_valid <= 1'b1;
            dp.resp_error <= 1'b0;
            dp.resp_rdata <= is_store(op_q) ? '0 : extend_load(op_q, asm_next);
          end else begin
            beat_q <= beat_q + 2'd1;
            mem_q  <= mem_drive(op_q, addr_q, wdata_q, 1'b1, nbeats_q, beat_q + 2'd1);
          end
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          dp.req_ready  <= 1'b1;
          dp.resp_valid <= 1'b0;
          dp.resp_rdata <= '0;
          dp.resp_error <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_address        = mem_q.address;
  assign mem_data_in        = mem_q.data_in;
  assign mem_read           = mem_q.read;
  assign mem_write          = mem_q.write;
  assign mem_half_word_mode = mem_q.half_word_mode;
  assign mem_byte_mode      = mem_q.byte_mode;
  assign mem_unsigned_mode  = mem_q.unsigned_mode;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the byte-addressed data memory port: accepts load/store requests from the datapath over a valid/ready handshake and drives the memory's address, data, read/write and size/extension controls.
- Aligned accesses take one memory beat.
- Misaligned halfword/word accesses are split into sequential byte beats and reassembled big-endian.
- Sits between the execute stage and data memory.

Parameters:
- MEM_BYTES, 1024: memory depth in bytes; accesses touching any byte at or above this are rejected.
- SPLIT_MISALIGNED, 1: 1 = split misaligned accesses into byte beats; 0 = reject them with resp_error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, request accepted on clk edge when valid&ready.
- req_op  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified for SH/SB.
- resp_valid  out  1  one-cycle pulse, access complete.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid; out-of-range or rejected misaligned access.
- mem_address  out  32  to memory address.
- mem_data_in  out  32  to memory write data.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_half_word_mode  out  1  halfword size select.
- mem_byte_mode  out  1  byte size select.
- mem_unsigned_mode  out  1  memory-side zero extension.
- mem_data_out  in  32  memory read data.

Behaviour:
- Reset (async): state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_error=0; all mem_* outputs 0; beat counter 0; assembly register 0.
- FSM states: IDLE, ACCESS, SPLIT, RESP.
- IDLE -> ACCESS: on accept of an aligned in-range request.
- IDLE -> SPLIT: on accept of a misaligned in-range request when SPLIT_MISALIGNED=1.
- IDLE -> RESP: on accept of an out-of-range request, or a misaligned one when SPLIT_MISALIGNED=0. resp_error=1; no memory beat is issued.
- Alignment rules: word requires addr[1:0]=0; halfword requires addr[0]=0; bytes are always aligned.
- Range check: addr+size-1 < MEM_BYTES, computed in 33 bits so 32-bit wrap-around counts as out of range.
- req_ready is 1 only in IDLE. Request fields are registered on accept; req_* are don't-care afterward.
- ACCESS (1 cycle):
  - mem_address = addr.
  - Size flags follow the op: word 0/0, half 1/0, byte 0/1.
  - mem_unsigned_mode is always 1 on reads; sign extension is done inside this unit from bit 15 (LH) or bit 7 (LB).
  - Loads: mem_read=1, mem_write=0; mem_data_out is sampled at the closing edge.
  - Stores: mem_write=1, mem_read=0, mem_data_in = registered wdata; the memory commits at the closing edge.
- SPLIT (N beats, N=4 word, 2 halfword):
  - Beat i: mem_address = addr+i, byte_mode=1, half_word_mode=0.
  - Loads: byte i is captured into assembly bits [8*(N-1-i)+7 : 8*(N-1-i)] (big-endian).
  - Stores: mem_data_in[7:0] = wdata byte (N-1-i), taking the most-significant byte first.
  - After beat N-1 the FSM goes to RESP.
- RESP (1 cycle): resp_valid=1 with final rdata/error; all mem_* enables are 0; then IDLE.
- Latency from accept edge to resp_valid: aligned = 2 cycles; split word = 5; split half = 3; error = 1.
- Throughput: a new request can be accepted in the cycle after RESP; there is no back-to-back overlap.
- mem_read and mem_write are never 1 together. All mem_* outputs are registered and 0 outside ACCESS/SPLIT.
- Reset mid-operation clears the FSM and issues no response. Store beats already committed remain in memory; the datapath must treat the access as lost.

Decomposition:
- Shared package (lsu_pkg):
  - op encodings LW..SB;
  - size constants BYTE=1, HALF=2, WORD=4;
  - FSM state encodings;
  - helper functions is_store, op_size, op_signed.
- One natural sub-module, lsu_align_check (combinational):
  - inputs: op, addr, MEM_BYTES;
  - outputs: misaligned, out_of_range, beat count.
- Everything else (FSM, assembly register, memory drive) stays in the top module.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF, 2-cycle latency each, bytes 0x10..0x13 = DE,AD,BE,EF.
- SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080.
- SH 0x8001 @0x31 (misaligned, split) -> two byte beats @0x31=0x80, @0x32=0x01. Then LH @0x31 -> 0xFFFF8001 after 3 cycles; LHU -> 0x00008001.
- LW @0x102 split over memory holding 11,22,33,44 -> 0x11223344 after 5 cycles. Same request with SPLIT_MISALIGNED=0 -> resp_error=1, no mem_read pulse.
- LW @0x3FE (MEM_BYTES=1024) and LB @0xFFFFFFFF -> resp_error=1, resp_rdata=0, no memory enables asserted.
- Assert rst during beat 2 of a split SW -> outputs return to reset values immediately, no resp_valid. The next aligned LW completes normally with req_ready=1 after reset release.
